// File: rtl/bcd_gray_pkg.sv
// Shared types and helpers for the BCD counter / Gray encoding slice.
package bcd_gray_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  // Per-digit Gray code; the OR in bit 2 is exact for legal digits 0..9.
  function automatic bcd_digit_t bcd_to_gray(input bcd_digit_t b);
    bcd_digit_t g;
    g[3] = b[3];
    g[2] = b[3] | b[2];
    g[1] = b[2] ^ b[1];
    g[0] = b[1] ^ b[0];
    return g;
  endfunction

  // Decimal digit idx (0 = units) of a plain integer, used for reset values.
  function automatic bcd_digit_t init_digit(input int unsigned val, input int unsigned idx);
    int unsigned v;
    v = val;
    for (int unsigned i = 0; i < idx; i++) v = v / 10;
    return bcd_digit_t'(v % 10);
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One cascaded BCD digit with load, carry/borrow chain and Gray output.
// Build option: GRAY_OUT_REG_EN registers gray from the next digit state.
module bcd_digit_cell
  import bcd_gray_pkg::*;
#(
  parameter bcd_digit_t INIT_DIGIT = '0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_in,
  input  logic       up,
  input  logic       load,
  input  bcd_digit_t load_digit,
  output bcd_digit_t digit,
  output bcd_digit_t gray,
  output logic       step_out,
  output logic       bad_load
);

  bcd_digit_t digit_q, digit_d;
  logic       at_limit;

  // Next digit: load beats step; wrap at the direction's limit.
  always_comb begin
    at_limit = up ? (digit_q == BCD_MAX) : (digit_q == '0);
    step_out = step_in & at_limit;
    bad_load = load & (load_digit > BCD_MAX);
    digit_d  = digit_q;
    if (load) begin
      digit_d = bad_load ? '0 : load_digit;
    end else if (step_in) begin
      if (at_limit) digit_d = up ? '0 : BCD_MAX;
      else          digit_d = up ? digit_q + 4'd1 : digit_q - 4'd1;
    end
  end

  // Digit register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) digit_q <= INIT_DIGIT;
    else     digit_q <= digit_d;
  end

  assign digit = digit_q;

`ifdef GRAY_OUT_REG_EN
  bcd_digit_t gray_q, gray_d;

  // Encode the next state so the registered Gray stays aligned with digit_q.
  always_comb begin
    gray_d = bcd_to_gray(digit_d);
  end

  // Gray output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) gray_q <= bcd_to_gray(INIT_DIGIT);
    else     gray_q <= gray_d;
  end

  assign gray = gray_q;
`else
  assign gray = bcd_to_gray(digit_q);
`endif

endmodule

// File: rtl/bcd_gray_counter.sv
// Multi-digit BCD up/down counter with per-digit Gray output, terminal
// count and sticky invalid-load flag.
// Build option: GRAY_OUT_REG_EN (registered gray_out, same port timing).
module bcd_gray_counter
  import bcd_gray_pkg::*;
#(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned INIT_VAL = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic [4*DIGITS-1:0] gray_out,
  output logic                tc,
  output logic                load_err
);

  logic [DIGITS:0]   step;
  logic [DIGITS-1:0] bad;
  logic              load_err_q, load_err_d;

  assign step[0] = en;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_cell #(
      .INIT_DIGIT(init_digit(INIT_VAL, i))
    ) u_cell (
      .clk       (clk),
      .rst       (rst),
      .step_in   (step[i]),
      .up        (up),
      .load      (load),
      .load_digit(load_val[4*i +: 4]),
      .digit     (bcd_out[4*i +: 4]),
      .gray      (gray_out[4*i +: 4]),
      .step_out  (step[i+1]),
      .bad_load  (bad[i])
    );
  end

  // The ripple out of the top digit is en AND every digit at its limit,
  // which is exactly the terminal-count condition.
  assign tc = step[DIGITS];

  // Sticky error: any non-BCD digit on a load sets it until reset.
  always_comb begin
    load_err_d = load_err_q | (|bad);
  end

  // Error flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) load_err_q <= 1'b0;
    else     load_err_q <= load_err_d;
  end

  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_gray_counter.sv
// Self-checking bench for bcd_gray_counter (DIGITS=2, INIT_VAL=0).
module tb_bcd_gray_counter;

  localparam int unsigned D    = 2;
  localparam int unsigned INIT = 0;
  localparam int unsigned MOD  = 100;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en = 1'b0, up = 1'b1, load = 1'b0;
  logic [4*D-1:0] load_val = '0;
  logic [4*D-1:0] bcd_out, gray_out;
  logic           tc, load_err;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: plain decimal value plus error flag.
  int unsigned m_cnt = INIT;
  bit          m_err = 1'b0;

  bcd_gray_counter #(.DIGITS(D), .INIT_VAL(INIT)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .bcd_out(bcd_out), .gray_out(gray_out),
    .tc(tc), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4*D-1:0] to_bcd(input int unsigned v);
    logic [4*D-1:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Reflected binary code per digit (b ^ b>>1).
  function automatic logic [4*D-1:0] to_gray(input int unsigned v);
    logic [4*D-1:0] b, g;
    logic [3:0] d;
    b = to_bcd(v);
    g = '0;
    for (int i = 0; i < D; i++) begin
      d = b[4*i +: 4];
      g[4*i +: 4] = d ^ (d >> 1);
    end
    return g;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".bcd"},  32'(bcd_out),  32'(to_bcd(m_cnt)));
    chk({tag, ".gray"}, 32'(gray_out), 32'(to_gray(m_cnt)));
    chk({tag, ".err"},  32'(load_err), 32'(m_err));
  endtask

  // One clock: drive at negedge, check pre-edge state and tc, then advance model.
  task automatic cycle(input bit l, input logic [4*D-1:0] lv, input bit e, input bit u);
    bit exp_tc;
    int unsigned nv;
    @(negedge clk);
    load = l; load_val = lv; en = e; up = u;
    #1;
    exp_tc = e && (u ? (m_cnt == MOD - 1) : (m_cnt == 0));
    chk("tc", 32'(tc), 32'(exp_tc));
    check_state("cyc");
    @(posedge clk);
    if (l) begin
      nv = 0;
      for (int i = D - 1; i >= 0; i--) begin
        if (lv[4*i +: 4] > 4'd9) begin
          m_err = 1'b1;
          nv = nv * 10;
        end else begin
          nv = nv * 10 + int'(lv[4*i +: 4]);
        end
      end
      m_cnt = nv;
    end else if (e) begin
      m_cnt = u ? (m_cnt + 1) % MOD : (m_cnt + MOD - 1) % MOD;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; load = 1'b0; en = 1'b0;
    #1;
    m_cnt = INIT; m_err = 1'b0;
    check_state("rst");
    chk("rst.tc", 32'(tc), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // Increment walk 00..11.
    for (int i = 0; i < 12; i++) cycle(0, '0, 1, 1);
    #1 chk("walk.end", 32'(bcd_out), 32'h12);

    // Load 98 then count up through 99 -> 00.
    cycle(1, 8'h98, 0, 1);
    cycle(0, '0, 1, 1);
    cycle(0, '0, 1, 1);
    #1 chk("wrap_up.bcd", 32'(bcd_out), 32'h00);

    // Load 00 then count down through 99, 98.
    cycle(1, 8'h00, 0, 0);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 0);
    chk("wrap_dn.gray", 32'(gray_out), 32'hDC);

    // Invalid load 3C -> 30 with sticky error through 20 counts.
    cycle(1, 8'h3C, 0, 1);
    cycle(0, '0, 0, 1);
    chk("badload.bcd", 32'(bcd_out), 32'h30);
    chk("badload.err", 32'(load_err), 32'd1);
    for (int i = 0; i < 20; i++) cycle(0, '0, 1, 1);
    do_reset();

    // Load and enable together: load wins.
    cycle(1, 8'h45, 1, 1);
    cycle(0, '0, 0, 1);
    chk("load_prio", 32'(bcd_out), 32'h45);

    // Asynchronous reset mid-cycle while counting at 57.
    cycle(1, 8'h56, 0, 1);
    cycle(0, '0, 1, 1);
    @(negedge clk);
    #2;
    chk("pre_async", 32'(bcd_out), 32'h57);
    rst = 1'b1;
    #1;
    chk("async.bcd", 32'(bcd_out), 32'(to_bcd(INIT)));
    chk("async.gray", 32'(gray_out), 32'(to_gray(INIT)));
    chk("async.tc", 32'(tc), 32'd0);
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    m_cnt = INIT; m_err = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 7) == 0, 8'($urandom), $urandom_range(0, 3) != 0,
              1'($urandom));
      end
    end
    cycle(0, '0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
